// File: rtl/ecs_adc_spi_master_if.sv
// Bus between the dual-ADC SPI master and its host / ADC side.
// Carries the trigger request, the shared CNV/SCLK lines, both MISO lines and the sample outputs.
interface ecs_adc_spi_master_if #(
    parameter int DATA_WIDTH = 18
);
    logic                  trigger;
    logic                  busy;
    logic                  cnv;
    logic                  sclk;
    logic                  miso_x;
    logic                  miso_y;
    logic [DATA_WIDTH-1:0] data_x;
    logic [DATA_WIDTH-1:0] data_y;
    logic                  data_valid;

    // Handshake: trigger is a one-cycle request, honoured only while busy is low and
    // otherwise dropped; data_valid is a one-cycle strobe with no back-pressure, and
    // data_x/data_y hold their value until the next strobe.
    modport master (
        input  trigger,
        input  miso_x,
        input  miso_y,
        output busy,
        output cnv,
        output sclk,
        output data_x,
        output data_y,
        output data_valid
    );

    modport slave (
        output trigger,
        output miso_x,
        output miso_y,
        input  busy,
        input  cnv,
        input  sclk,
        input  data_x,
        input  data_y,
        input  data_valid
    );
endinterface

// File: rtl/ecs_adc_spi_master.sv
// Starts a conversion on two SPI ADCs, then clocks both out MSB-first on a shared SCLK.
// Defining ECS_SAMPLE_CNT_EN adds the 16-bit completed-sample counter on port sample_cnt.
module ecs_adc_spi_master #(
    parameter int DATA_WIDTH  = 18,
    parameter int SCLK_DIV    = 4,
    parameter int CONV_CYCLES = 70
) (
    input  logic                 clk,
    input  logic                 rst,
    ecs_adc_spi_master_if.master bus,
    output logic [1:0]           state_dbg
`ifdef ECS_SAMPLE_CNT_EN
    ,
    output logic [15:0]          sample_cnt
`endif
);
    localparam int CONV_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam int DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BIT_W  = $clog2(DATA_WIDTH);

    localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(CONV_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    generate
        if (DATA_WIDTH < 8 || DATA_WIDTH > 24 || SCLK_DIV < 1 || CONV_CYCLES < 1) begin : g_bad_params
            $error("ecs_adc_spi_master: parameter out of range");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_SHIFT   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CONV_W-1:0]     conv_cnt_q, conv_cnt_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  cnv_q, cnv_d;
    logic                  sclk_q, sclk_d;
    logic                  busy_q, busy_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] shx_q, shx_d;
    logic [DATA_WIDTH-1:0] shy_q, shy_d;
    logic [DATA_WIDTH-1:0] dx_q, dx_d;
    logic [DATA_WIDTH-1:0] dy_q, dy_d;
`ifdef ECS_SAMPLE_CNT_EN
    logic [15:0]           sample_cnt_q, sample_cnt_d;
`endif

    // Next-state and next-output logic; every output is a flop so the pins are glitch-free.
    always_comb begin
        state_d    = state_q;
        conv_cnt_d = conv_cnt_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        cnv_d      = cnv_q;
        sclk_d     = sclk_q;
        valid_d    = 1'b0;
        shx_d      = shx_q;
        shy_d      = shy_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
`ifdef ECS_SAMPLE_CNT_EN
        sample_cnt_d = sample_cnt_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (bus.trigger) begin
                    state_d    = S_CONVERT;
                    cnv_d      = 1'b1;
                    conv_cnt_d = CONV_LAST;
                end
            end

            S_CONVERT: begin
                if (conv_cnt_q == '0) begin
                    state_d   = S_SHIFT;
                    cnv_d     = 1'b0;
                    sclk_d    = 1'b0;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                end else begin
                    conv_cnt_d = conv_cnt_q - 1'b1;
                end
            end

            S_SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    sclk_d    = ~sclk_q;
                    if (!sclk_q) begin
                        // This edge drives sclk high, so it is also the capture edge.
                        shx_d = {shx_q[DATA_WIDTH-2:0], bus.miso_x};
                        shy_d = {shy_q[DATA_WIDTH-2:0], bus.miso_y};
                    end else if (bit_cnt_q == BIT_LAST) begin
                        state_d = S_DONE;
                        valid_d = 1'b1;
                        dx_d    = shx_q;
                        dy_d    = shy_q;
`ifdef ECS_SAMPLE_CNT_EN
                        sample_cnt_d = sample_cnt_q + 16'd1;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            conv_cnt_q <= '0;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            cnv_q      <= 1'b0;
            sclk_q     <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            shx_q      <= '0;
            shy_q      <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
`ifdef ECS_SAMPLE_CNT_EN
            sample_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            conv_cnt_q <= conv_cnt_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            cnv_q      <= cnv_d;
            sclk_q     <= sclk_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            shx_q      <= shx_d;
            shy_q      <= shy_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
`ifdef ECS_SAMPLE_CNT_EN
            sample_cnt_q <= sample_cnt_d;
`endif
        end
    end

    assign bus.busy       = busy_q;
    assign bus.cnv        = cnv_q;
    assign bus.sclk       = sclk_q;
    assign bus.data_x     = dx_q;
    assign bus.data_y     = dy_q;
    assign bus.data_valid = valid_q;
    assign state_dbg      = state_q;
`ifdef ECS_SAMPLE_CNT_EN
    assign sample_cnt     = sample_cnt_q;
`endif
endmodule

// File: tb/tb_ecs_adc_spi_master.sv
// Bench for ecs_adc_spi_master: default build (18b/div 4/conv 70) and a small build (16b/div 1/conv 3).
// With ECS_SAMPLE_CNT_EN defined it also follows the sample counter across its wrap.
module tb_ecs_adc_spi_master;
    localparam int W = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q[$];

    ecs_adc_spi_master_if #(.DATA_WIDTH(18)) m_if();
    ecs_adc_spi_master_if #(.DATA_WIDTH(16)) s_if();
    logic [1:0] m_state;
    logic [1:0] s_state;
`ifdef ECS_SAMPLE_CNT_EN
    logic [15:0] m_cnt;
    logic [15:0] s_cnt;
    logic [15:0] exp_cnt_m = '0;
    logic [15:0] exp_cnt_s = '0;
`endif

    ecs_adc_spi_master dut_m (
        .clk       (clk),
        .rst       (rst),
        .bus       (m_if.master),
        .state_dbg (m_state)
`ifdef ECS_SAMPLE_CNT_EN
        ,
        .sample_cnt(m_cnt)
`endif
    );

    ecs_adc_spi_master #(.DATA_WIDTH(16), .SCLK_DIV(1), .CONV_CYCLES(3)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .bus       (s_if.master),
        .state_dbg (s_state)
`ifdef ECS_SAMPLE_CNT_EN
        ,
        .sample_cnt(s_cnt)
`endif
    );

    // Stimulus steering: sel picks which instance the directed steps talk to.
    logic sel = 1'b0;
    logic trig = 1'b0;
    assign m_if.trigger = trig & ~sel;
    assign s_if.trigger = trig & sel;

    // ADC models: word latched on CNV rise, next bit presented after each SCLK rise.
    logic [31:0] tx_x = '0;
    logic [31:0] tx_y = '0;
    logic [31:0] sh_mx = '0, sh_my = '0, sh_sx = '0, sh_sy = '0;
    always @(posedge m_if.cnv) begin sh_mx = tx_x << 14; sh_my = tx_y << 14; end
    always @(posedge m_if.sclk) begin sh_mx = sh_mx << 1; sh_my = sh_my << 1; end
    always @(posedge s_if.cnv) begin sh_sx = tx_x << 16; sh_sy = tx_y << 16; end
    always @(posedge s_if.sclk) begin sh_sx = sh_sx << 1; sh_sy = sh_sy << 1; end
    assign m_if.miso_x = sh_mx[31];
    assign m_if.miso_y = sh_my[31];
    assign s_if.miso_x = sh_sx[31];
    assign s_if.miso_y = sh_sy[31];

    logic        o_busy, o_cnv, o_sclk, o_valid;
    logic [31:0] o_dx, o_dy;
    assign o_busy  = sel ? s_if.busy : m_if.busy;
    assign o_cnv   = sel ? s_if.cnv : m_if.cnv;
    assign o_sclk  = sel ? s_if.sclk : m_if.sclk;
    assign o_valid = sel ? s_if.data_valid : m_if.data_valid;
    assign o_dx    = sel ? 32'(s_if.data_x) : 32'(m_if.data_x);
    assign o_dy    = sel ? 32'(s_if.data_y) : 32'(m_if.data_y);

    logic [31:0] last_x = '0;
    logic [31:0] last_y = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic score_valid();
        logic [W-1:0] e;
        check("valid_has_expect", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("data_x", o_dx, e[63:32]);
            check("data_y", o_dy, e[31:0]);
            last_x = e[63:32];
            last_y = e[31:0];
        end
`ifdef ECS_SAMPLE_CNT_EN
        if (sel) exp_cnt_s = exp_cnt_s + 16'd1;
        else     exp_cnt_m = exp_cnt_m + 16'd1;
        check("sample_cnt", 32'(sel ? s_cnt : m_cnt), 32'(sel ? exp_cnt_s : exp_cnt_m));
`endif
    endtask

    // One trigger plus observation window; optional ignored triggers, mid-run reset, or re-trigger right after DONE.
    task automatic run_sample(input logic [31:0] x, input logic [31:0] y,
                              input int extra1, input int extra2, input int rst_at, input bit chain);
        int lat, conv, nb;
        int cnv_n = 0, cnv_first = -1, cnv_last = -1;
        int busy_n = 0, busy_first = -1, busy_last = -1;
        int rise_n = 0, valid_n = 0, valid_at = -1;
        bit got_chain = 1'b0;
        logic prev_sclk = 1'b0;
        logic [31:0] mask;
        lat  = sel ? 36 : 215;
        conv = sel ? 3 : 70;
        nb   = sel ? 16 : 18;
        mask = sel ? 32'h0000_FFFF : 32'h0003_FFFF;
        @(negedge clk);
        tx_x = x & mask;
        tx_y = y & mask;
        trig = 1'b1;
        if (rst_at < 0) exp_q.push_back({tx_x, tx_y});
        for (int k = 1; k <= lat + 3; k++) begin
            @(negedge clk);
            if (o_valid) begin
                valid_n++;
                valid_at = k;
                score_valid();
            end
            if (k <= lat) begin
                if (o_cnv) begin cnv_n++; if (cnv_first < 0) cnv_first = k; cnv_last = k; end
                if (o_busy) begin busy_n++; if (busy_first < 0) busy_first = k; busy_last = k; end
                if (o_sclk && !prev_sclk) rise_n++;
            end
            prev_sclk = o_sclk;
            trig = 1'b0;
            if (rst_at > 0 && k == rst_at + 1) begin
                check("rst_busy", 32'(o_busy), 32'd0);
                check("rst_cnv", 32'(o_cnv), 32'd0);
                check("rst_sclk", 32'(o_sclk), 32'd0);
                check("rst_data_x", o_dx, 32'd0);
                check("rst_data_y", o_dy, 32'd0);
                rst = 1'b0;
                last_x = '0;
                last_y = '0;
`ifdef ECS_SAMPLE_CNT_EN
                exp_cnt_m = '0;
                exp_cnt_s = '0;
`endif
            end
            if (rst_at > 0 && k == rst_at) rst = 1'b1;
            if (k == extra1 || k == extra2) trig = 1'b1;
            if (chain && k == lat + 1) begin
                trig = 1'b1;
                exp_q.push_back({tx_x, tx_y});
            end
            if (chain && k == lat + 2) check("retrigger_accepted", 32'(o_busy), 32'd1);
        end
        trig = 1'b0;
        if (rst_at > 0) begin
            check("rst_no_valid", 32'(valid_n), 32'd0);
            check("rst_data_x_kept", o_dx, 32'd0);
        end else begin
            check("valid_count", 32'(valid_n), 32'd1);
            check("valid_latency", 32'(valid_at), 32'(lat));
            check("cnv_cycles", 32'(cnv_n), 32'(conv));
            check("cnv_first", 32'(cnv_first), 32'd1);
            check("cnv_last", 32'(cnv_last), 32'(conv));
            check("sclk_rises", 32'(rise_n), 32'(nb));
            check("busy_cycles", 32'(busy_n), 32'(lat));
            check("busy_first", 32'(busy_first), 32'd1);
            check("busy_last", 32'(busy_last), 32'(lat));
        end
        if (chain) begin
            for (int k = lat + 4; k <= 2 * lat + 20; k++) begin
                @(negedge clk);
                if (o_valid) begin
                    check("chain_latency", 32'(k), 32'(2 * lat + 1));
                    score_valid();
                    got_chain = 1'b1;
                    break;
                end
            end
            check("chain_valid_seen", 32'(got_chain), 32'd1);
        end
        @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, with a trigger held during reset that must be dropped.
        repeat (3) @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        trig = 1'b0;
        @(negedge clk);
        check("reset_busy_m", 32'(m_if.busy), 32'd0);
        check("reset_busy_s", 32'(s_if.busy), 32'd0);
        check("reset_cnv_m", 32'(m_if.cnv), 32'd0);
        check("reset_sclk_m", 32'(m_if.sclk), 32'd0);
        check("reset_valid_m", 32'(m_if.data_valid), 32'd0);
        check("reset_data_x_m", 32'(m_if.data_x), 32'd0);
        check("reset_data_y_m", 32'(m_if.data_y), 32'd0);
        check("reset_data_x_s", 32'(s_if.data_x), 32'd0);
        check("reset_state_m", 32'(m_state), 32'd0);
        check("reset_state_s", 32'(s_state), 32'd0);
`ifdef ECS_SAMPLE_CNT_EN
        check("reset_cnt_m", 32'(m_cnt), 32'd0);
`endif

        sel = 1'b0;
        run_sample(32'h2A5A5, 32'h15A5A, -1, -1, -1, 1'b0);
        repeat (10) @(negedge clk);
        check("hold_data_x", o_dx, last_x);
        check("hold_data_y", o_dy, last_y);
        check("hold_no_valid", 32'(o_valid), 32'd0);

        run_sample(32'h3FFFF, 32'h00000, -1, -1, -1, 1'b0);
        run_sample(32'($urandom_range(0, 32'h3FFFF)), 32'($urandom_range(0, 32'h3FFFF)), 100, 215, -1, 1'b1);
        run_sample(32'($urandom_range(0, 32'h3FFFF)), 32'($urandom_range(0, 32'h3FFFF)), -1, -1, 120, 1'b0);
        run_sample(32'($urandom_range(0, 32'h3FFFF)), 32'($urandom_range(0, 32'h3FFFF)), -1, -1, -1, 1'b0);
        check("queue_drained_m", 32'(exp_q.size()), 32'd0);

        sel = 1'b1;
        run_sample(32'hBEEF, 32'hBEEF, -1, -1, -1, 1'b0);
        run_sample(32'($urandom_range(0, 32'hFFFF)), 32'($urandom_range(0, 32'hFFFF)), 20, 36, -1, 1'b1);
        repeat (5) @(negedge clk);
        check("hold_data_x_s", o_dx, last_x);

`ifdef ECS_SAMPLE_CNT_EN
        sel = 1'b0;
        @(negedge clk);
        force dut_m.sample_cnt_q = 16'hFFFE;
        #1;
        release dut_m.sample_cnt_q;
        exp_cnt_m = 16'hFFFE;
        for (int i = 0; i < 3; i++)
            run_sample(32'($urandom_range(0, 32'h3FFFF)), 32'($urandom_range(0, 32'h3FFFF)), -1, -1, -1, 1'b0);
        check("cnt_after_wrap", 32'(m_cnt), 32'h0001);
`endif

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
